// File: rtl/output_manager.sv
// Front-panel output manager for the SAP1 board: drives four active-low 7-segment digits and
// ten status LEDs, showing a mode banner after every mode change and then the per-mode view.
module output_manager #(
    parameter int BANNER_CYCLES = 50_000_000,
    parameter int PAGE_CYCLES   = 100_000_000,
    parameter int BLINK_HALF    = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] masterMode,
    input  logic       subMode3,
    input  logic [3:0] ram_addr,
    input  logic [7:0] ram_data,
    input  logic [3:0] sap_pc,
    input  logic [7:0] sap_a,
    input  logic [7:0] sap_b,
    input  logic [7:0] sap_out,
    input  logic       sap_halt,
    input  logic       page_step,
    output logic [6:0] HEX3,
    output logic [6:0] HEX2,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0,
    output logic [9:0] LEDR
);
    localparam int BW = $clog2(BANNER_CYCLES + 1);
    localparam int PW = $clog2(PAGE_CYCLES + 1);
    localparam int KW = $clog2(BLINK_HALF + 1);

    // Reset loads one extra count so the banner is seen for the full duration after release.
    localparam logic [BW-1:0] BANNER_LOAD  = BW'(BANNER_CYCLES - 1);
    localparam logic [BW-1:0] BANNER_RESET = BW'(BANNER_CYCLES);
    localparam logic [PW-1:0] PAGE_LAST    = PW'(PAGE_CYCLES - 1);
    localparam logic [KW-1:0] BLINK_LAST   = KW'(BLINK_HALF - 1);
    localparam logic [6:0]    SEG_BLANK    = 7'h7F;
    localparam logic [6:0]    SEG_DASH     = 7'h3F;

    typedef enum logic {BANNER, SHOW} state_t;
    typedef enum logic [1:0] {K_DIGIT, K_BLANK, K_DASH} kind_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] banner_cnt_reg, banner_cnt_next;
    logic [1:0]    mode_reg, mode_next;
    logic [1:0]    page_reg, page_next;
    logic [PW-1:0] page_cnt_reg, page_cnt_next;
    logic          blink_reg, blink_next;
    logic [KW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          step_prev_reg;
    logic          sub_prev_reg;
    logic [6:0]    hex_reg [4];
    logic [9:0]    ledr_reg;

    logic          mode_change;
    logic          step_rise;
    logic          sub_toggle;
    logic          page_adv;

    kind_t         kind [4];
    logic [3:0]    nib [4];
    logic [6:0]    hex_enc [4];
    logic [9:0]    ledr_next;
    logic [7:0]    sel_byte;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        mode_change     = (masterMode != mode_reg);
        step_rise       = page_step & ~step_prev_reg;
        sub_toggle      = (subMode3 != sub_prev_reg);
        state_next      = state_reg;
        banner_cnt_next = banner_cnt_reg;
        mode_next       = mode_reg;
        page_next       = page_reg;
        page_cnt_next   = page_cnt_reg;
        blink_next      = blink_reg;
        blink_cnt_next  = blink_cnt_reg;
        page_adv        = 1'b0;

        if (mode_change) begin
            // A mode change wins over any page event arriving in the same cycle.
            state_next      = BANNER;
            banner_cnt_next = BANNER_LOAD;
            mode_next       = masterMode;
            if (masterMode == 2'd1) begin
                blink_next     = 1'b1;
                blink_cnt_next = '0;
            end
            if (masterMode == 2'd2) begin
                page_next     = '0;
                page_cnt_next = '0;
            end
        end else begin
            if (state_reg == BANNER) begin
                if (banner_cnt_reg == '0) begin
                    state_next = SHOW;
                end else begin
                    banner_cnt_next = banner_cnt_reg - BW'(1);
                end
            end

            if (mode_reg == 2'd1 && state_reg == SHOW) begin
                if (blink_cnt_reg == BLINK_LAST) begin
                    blink_cnt_next = '0;
                    blink_next     = ~blink_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + KW'(1);
                end
            end

            if (sap_halt) begin
                page_next = 2'd3;
            end
            if (sub_toggle) begin
                page_cnt_next = '0;
            end else if (!sap_halt && mode_reg == 2'd2 && subMode3 && state_reg == SHOW) begin
                if (page_cnt_reg == PAGE_LAST) begin
                    page_cnt_next = '0;
                    page_adv      = 1'b1;
                end else begin
                    page_cnt_next = page_cnt_reg + PW'(1);
                end
            end
            if (!sap_halt && mode_reg == 2'd2 && !subMode3 && step_rise) begin
                page_adv = 1'b1;
            end
            if (page_adv) begin
                page_next = page_reg + 2'd1;
            end
        end
    end

    always_comb begin
        kind      = '{default: K_BLANK};
        nib       = '{default: 4'h0};
        ledr_next = {mode_next, 8'h00};

        case (page_next)
            2'd0:    sel_byte = {4'h0, sap_pc};
            2'd1:    sel_byte = sap_a;
            2'd2:    sel_byte = sap_b;
            default: sel_byte = sap_out;
        endcase

        if (state_next == BANNER) begin
            kind[3] = K_DASH;
            kind[2] = K_DASH;
            kind[0] = K_DIGIT;
            nib[0]  = {2'b00, mode_next};
        end else begin
            case (mode_next)
                2'd2: begin
                    kind[3]   = K_DIGIT;
                    nib[3]    = {2'b00, page_next};
                    kind[1]   = K_DIGIT;
                    nib[1]    = sel_byte[7:4];
                    kind[0]   = K_DIGIT;
                    nib[0]    = sel_byte[3:0];
                    ledr_next = {mode_next, sap_out};
                end
                2'd3: begin
                    kind[0]   = K_DIGIT;
                    nib[0]    = {3'b000, subMode3};
                    ledr_next = {mode_next, ram_data};
                end
                default: begin
                    kind[2]   = (mode_next == 2'd1 && !blink_next) ? K_BLANK : K_DIGIT;
                    nib[2]    = ram_addr;
                    kind[1]   = K_DIGIT;
                    nib[1]    = ram_data[7:4];
                    kind[0]   = K_DIGIT;
                    nib[0]    = ram_data[3:0];
                    ledr_next = {mode_next, ram_data};
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_enc
            assign hex_enc[gi] = (kind[gi] == K_DASH)  ? SEG_DASH  :
                                 (kind[gi] == K_BLANK) ? SEG_BLANK : seg7(nib[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= BANNER;
            banner_cnt_reg <= BANNER_RESET;
            mode_reg       <= masterMode;
            page_reg       <= '0;
            page_cnt_reg   <= '0;
            blink_reg      <= 1'b1;
            blink_cnt_reg  <= '0;
            step_prev_reg  <= 1'b0;
            sub_prev_reg   <= subMode3;
            for (int i = 0; i < 4; i++) begin
                hex_reg[i] <= SEG_BLANK;
            end
            ledr_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            banner_cnt_reg <= banner_cnt_next;
            mode_reg       <= mode_next;
            page_reg       <= page_next;
            page_cnt_reg   <= page_cnt_next;
            blink_reg      <= blink_next;
            blink_cnt_reg  <= blink_cnt_next;
            step_prev_reg  <= page_step;
            sub_prev_reg   <= subMode3;
            for (int i = 0; i < 4; i++) begin
                hex_reg[i] <= hex_enc[i];
            end
            ledr_reg       <= ledr_next;
        end
    end

    assign HEX3 = hex_reg[3];
    assign HEX2 = hex_reg[2];
    assign HEX1 = hex_reg[1];
    assign HEX0 = hex_reg[0];
    assign LEDR = ledr_reg;

endmodule

// File: tb/tb_output_manager.sv
// Bench for output_manager: directed front-panel scenarios with literal expectations, then a
// randomized run compared every cycle against a cycle-level behavioural model.
module tb_output_manager;
    localparam int B  = 4;
    localparam int P  = 6;
    localparam int BH = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] masterMode;
    logic       subMode3;
    logic [3:0] ram_addr;
    logic [7:0] ram_data;
    logic [3:0] sap_pc;
    logic [7:0] sap_a;
    logic [7:0] sap_b;
    logic [7:0] sap_out;
    logic       sap_halt;
    logic       page_step;
    logic [6:0] HEX3, HEX2, HEX1, HEX0;
    logic [9:0] LEDR;

    output_manager #(.BANNER_CYCLES(B), .PAGE_CYCLES(P), .BLINK_HALF(BH)) dut (
        .clk(clk), .rst_n(rst_n), .masterMode(masterMode), .subMode3(subMode3),
        .ram_addr(ram_addr), .ram_data(ram_data), .sap_pc(sap_pc), .sap_a(sap_a),
        .sap_b(sap_b), .sap_out(sap_out), .sap_halt(sap_halt), .page_step(page_step),
        .HEX3(HEX3), .HEX2(HEX2), .HEX1(HEX1), .HEX0(HEX0), .LEDR(LEDR)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [6:0] seg_tab [16];

    // Model state: banner cycles still to display, what was shown last cycle, and page/blink timing.
    logic [1:0] m_mode;
    int         m_left;
    bit         m_showing;
    int         m_page;
    int         m_ptime;
    bit         m_blink;
    int         m_btime;
    bit         m_prev_step;
    bit         m_prev_sub;
    logic [6:0] exp_hex [4];
    logic [9:0] exp_ledr;

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, got, want);
    endtask

    task automatic model_step();
        bit changed, rise, toggled, adv;
        logic [7:0] byte_v;
        if (!rst_n) begin
            m_mode = masterMode; m_left = B; m_showing = 0;
            m_page = 0; m_ptime = 0; m_blink = 1; m_btime = 0;
            m_prev_step = 0; m_prev_sub = subMode3;
            for (int i = 0; i < 4; i++) exp_hex[i] = 7'h7F;
            exp_ledr = '0;
            return;
        end
        changed = (masterMode != m_mode);
        rise    = page_step && !m_prev_step;
        toggled = (subMode3 != m_prev_sub);
        adv     = 0;
        if (changed) begin
            m_mode = masterMode;
            m_left = B;
            if (m_mode == 2'd1) begin m_blink = 1; m_btime = 0; end
            if (m_mode == 2'd2) begin m_page = 0; m_ptime = 0; end
        end else begin
            if (m_mode == 2'd1 && m_showing) begin
                m_btime++;
                if (m_btime == BH) begin m_btime = 0; m_blink = !m_blink; end
            end
            if (toggled) m_ptime = 0;
            if (sap_halt) begin
                m_page = 3;
            end else begin
                if (!toggled && m_mode == 2'd2 && subMode3 && m_showing) begin
                    m_ptime++;
                    if (m_ptime == P) begin m_ptime = 0; adv = 1; end
                end
                if (m_mode == 2'd2 && !subMode3 && rise) adv = 1;
                if (adv) m_page = (m_page + 1) % 4;
            end
        end
        m_prev_step = page_step;
        m_prev_sub  = subMode3;

        if (m_left > 0) begin
            m_left--;
            m_showing = 0;
            exp_hex[3] = 7'h3F; exp_hex[2] = 7'h3F; exp_hex[1] = 7'h7F;
            exp_hex[0] = seg_tab[{2'b00, m_mode}];
            exp_ledr   = {m_mode, 8'h00};
        end else begin
            m_showing = 1;
            case (m_mode)
                2'd2: begin
                    case (m_page)
                        0:       byte_v = {4'h0, sap_pc};
                        1:       byte_v = sap_a;
                        2:       byte_v = sap_b;
                        default: byte_v = sap_out;
                    endcase
                    exp_hex[3] = seg_tab[m_page];
                    exp_hex[2] = 7'h7F;
                    exp_hex[1] = seg_tab[byte_v[7:4]];
                    exp_hex[0] = seg_tab[byte_v[3:0]];
                    exp_ledr   = {m_mode, sap_out};
                end
                2'd3: begin
                    exp_hex[3] = 7'h7F; exp_hex[2] = 7'h7F; exp_hex[1] = 7'h7F;
                    exp_hex[0] = seg_tab[{3'b000, subMode3}];
                    exp_ledr   = {m_mode, ram_data};
                end
                default: begin
                    exp_hex[3] = 7'h7F;
                    exp_hex[2] = (m_mode == 2'd1 && !m_blink) ? 7'h7F : seg_tab[ram_addr];
                    exp_hex[1] = seg_tab[ram_data[7:4]];
                    exp_hex[0] = seg_tab[ram_data[3:0]];
                    exp_ledr   = {m_mode, ram_data};
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        check("HEX3", HEX3, exp_hex[3]);
        check("HEX2", HEX2, exp_hex[2]);
        check("HEX1", HEX1, exp_hex[1]);
        check("HEX0", HEX0, exp_hex[0]);
        check("LEDR", LEDR, exp_ledr);
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n = 0; masterMode = 0; subMode3 = 0; ram_addr = 0; ram_data = 0;
        sap_pc = 0; sap_a = 0; sap_b = 0; sap_out = 0; sap_halt = 0; page_step = 0;
        tick(); tick();
        check("rst_hex3", HEX3, 7'h7F); check("rst_hex0", HEX0, 7'h7F);
        check("rst_ledr", LEDR, 10'h000);

        // Power-up banner then RAM read view.
        ram_addr = 4'hA; ram_data = 8'h3C; rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ban0_hex3", HEX3, 7'h3F); check("ban0_hex2", HEX2, 7'h3F);
            check("ban0_hex1", HEX1, 7'h7F); check("ban0_hex0", HEX0, 7'h40);
        end
        tick();
        check("rd_hex3", HEX3, 7'h7F); check("rd_hex2", HEX2, 7'h08);
        check("rd_hex1", HEX1, 7'h30); check("rd_hex0", HEX0, 7'h46);
        check("rd_ledr", LEDR, 10'h03C);

        // Write mode: address digit blinks every 3 cycles, starting visible.
        masterMode = 2'd1;
        for (int i = 0; i < 4; i++) begin tick(); check("ban1_hex0", HEX0, 7'h79); end
        for (int k = 0; k < 9; k++) begin
            tick();
            check("blink_hex2", HEX2, ((k / 3) % 2 == 0) ? 7'h08 : 7'h7F);
        end

        // Run mode, auto paging.
        masterMode = 2'd2; subMode3 = 1; sap_pc = 4'h5; sap_a = 8'h12; sap_b = 8'h9E; sap_out = 8'h7D;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("pg0_hex3", HEX3, 7'h40); check("pg0_hex1", HEX1, 7'h40);
            check("pg0_hex0", HEX0, 7'h12); check("pg0_ledr", LEDR, 10'h27D);
        end
        tick();
        check("pg1_hex3", HEX3, 7'h79); check("pg1_hex1", HEX1, 7'h79); check("pg1_hex0", HEX0, 7'h24);
        for (int i = 0; i < 18; i++) tick();
        check("wrap_hex3", HEX3, 7'h40);

        // Manual paging: a held step advances once; halt pins page 3.
        subMode3 = 0;
        tick(); check("man_hex3", HEX3, 7'h40);
        page_step = 1;
        for (int i = 0; i < 10; i++) begin tick(); check("step_hex3", HEX3, 7'h79); end
        page_step = 0; tick();
        sap_halt = 1; tick(); check("halt_hex3", HEX3, 7'h30);
        for (int i = 0; i < 4; i++) begin
            page_step = ~page_step; tick(); check("halt_step_hex3", HEX3, 7'h30);
        end
        sap_halt = 0; page_step = 0; tick();

        // Mode change during banner restarts the full banner.
        masterMode = 2'd3; tick(); check("ban3_hex0", HEX0, 7'h30);
        masterMode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("reban_hex3", HEX3, 7'h3F); check("reban_hex0", HEX0, 7'h40);
        end
        tick(); check("reban_end_hex3", HEX3, 7'h7F);

        // Reset in the middle of run mode at page 2.
        masterMode = 2'd2; subMode3 = 1;
        for (int i = 0; i < 17; i++) tick();
        check("pg2_hex3", HEX3, 7'h24);
        rst_n = 0; tick();
        check("mid_rst_hex3", HEX3, 7'h7F); check("mid_rst_hex1", HEX1, 7'h7F);
        check("mid_rst_ledr", LEDR, 10'h000);
        rst_n = 1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_hex3", HEX3, 7'h40);

        // Randomized run against the model.
        for (int n = 0; n < 4000; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 29) == 0) masterMode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) subMode3 = ~subMode3;
            if ($urandom_range(0, 2) == 0) page_step = ~page_step;
            if (sap_halt) begin if ($urandom_range(0, 5) == 0) sap_halt = 0; end
            else if ($urandom_range(0, 39) == 0) sap_halt = 1;
            ram_addr = 4'($urandom); ram_data = 8'($urandom);
            sap_pc = 4'($urandom); sap_a = 8'($urandom); sap_b = 8'($urandom); sap_out = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
